// File: rtl/bp_cacc_csr_slave.sv
// CSR slave for the dot-product accelerator: terminates I/O CCE uncached commands,
// holds the 8 x 64b register window and sequences the engine start/done handshake.
module bp_cacc_csr_slave #(
  parameter int                       paddr_width_p   = 40,
  parameter int                       dword_width_p   = 64,
  parameter logic [paddr_width_p-1:0] csr_base_addr_p = '0
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     io_cmd_v_i,
  output logic                     io_cmd_ready_o,
  input  logic                     io_cmd_wr_i,
  input  logic [paddr_width_p-1:0] io_cmd_addr_i,
  input  logic [1:0]               io_cmd_size_i,
  input  logic [dword_width_p-1:0] io_cmd_data_i,

  output logic                     io_resp_v_o,
  input  logic                     io_resp_yumi_i,
  output logic                     io_resp_wr_o,
  output logic [paddr_width_p-1:0] io_resp_addr_o,
  output logic [1:0]               io_resp_size_o,
  output logic [dword_width_p-1:0] io_resp_data_o,

  output logic                     start_o,
  output logic [paddr_width_p-1:0] a_ptr_o,
  output logic [paddr_width_p-1:0] b_ptr_o,
  output logic [paddr_width_p-1:0] res_ptr_o,
  output logic [31:0]              len_o,
  input  logic                     done_i,
  input  logic [dword_width_p-1:0] result_i
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RESP = 1'b1;
  localparam logic E_IDLE = 1'b0;
  localparam logic E_BUSY = 1'b1;

  localparam logic [2:0] CSR_START   = 3'd0;
  localparam logic [2:0] CSR_STATUS  = 3'd1;
  localparam logic [2:0] CSR_A_PTR   = 3'd2;
  localparam logic [2:0] CSR_B_PTR   = 3'd3;
  localparam logic [2:0] CSR_LEN     = 3'd4;
  localparam logic [2:0] CSR_RES_PTR = 3'd5;
  localparam logic [2:0] CSR_RESULT  = 3'd6;
  localparam logic [2:0] CSR_CLEAR   = 3'd7;

  logic                     cmd_state_q, cmd_state_d;
  logic                     eng_state_q, eng_state_d;
  logic                     start_q, start_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic [dword_width_p-1:0] a_ptr_q, a_ptr_d;
  logic [dword_width_p-1:0] b_ptr_q, b_ptr_d;
  logic [dword_width_p-1:0] res_ptr_q, res_ptr_d;
  logic [31:0]              len_q, len_d;
  logic [dword_width_p-1:0] result_q, result_d;

  logic                     resp_wr_q, resp_wr_d;
  logic [paddr_width_p-1:0] resp_addr_q, resp_addr_d;
  logic [1:0]               resp_size_q, resp_size_d;
  logic [dword_width_p-1:0] resp_data_q, resp_data_d;

  logic                     accept;
  logic                     busy;
  logic                     in_win;
  logic                     aligned;
  logic [2:0]               idx;
  logic                     wr_ok;
  logic                     err_set;
  logic                     ptr_reg;
  logic                     launch;
  logic [dword_width_p-1:0] rd_data;

  assign busy    = (eng_state_q == E_BUSY);
  assign accept  = io_cmd_v_i && (cmd_state_q == S_IDLE);
  // Base is 64B aligned, so window membership is a compare of the upper address bits.
  assign in_win  = (io_cmd_addr_i[paddr_width_p-1:6] == csr_base_addr_p[paddr_width_p-1:6]);
  assign aligned = (io_cmd_addr_i[2:0] == 3'b000);
  assign idx     = io_cmd_addr_i[5:3];
  assign wr_ok   = accept && io_cmd_wr_i && in_win && aligned && (io_cmd_size_i == 2'd3);
  assign ptr_reg = (idx == CSR_A_PTR) || (idx == CSR_B_PTR) ||
                   (idx == CSR_LEN)   || (idx == CSR_RES_PTR);
  assign launch  = wr_ok && (idx == CSR_START) && io_cmd_data_i[0];

  always_comb begin
    rd_data = '0;
    case (idx)
      CSR_STATUS:  rd_data = {{(dword_width_p-3){1'b0}}, err_q, done_q, busy};
      CSR_A_PTR:   rd_data = a_ptr_q;
      CSR_B_PTR:   rd_data = b_ptr_q;
      CSR_LEN:     rd_data = {{(dword_width_p-32){1'b0}}, len_q};
      CSR_RES_PTR: rd_data = res_ptr_q;
      CSR_RESULT:  rd_data = result_q;
      default:     rd_data = '0;
    endcase
  end

  always_comb begin
    err_set = 1'b0;
    if (accept) begin
      if (io_cmd_wr_i && (io_cmd_size_i != 2'd3)) err_set = 1'b1;
      if (!in_win || !aligned)                    err_set = 1'b1;
      if (wr_ok && ((idx == CSR_STATUS) || (idx == CSR_RESULT))) err_set = 1'b1;
      if (wr_ok && busy && ptr_reg)               err_set = 1'b1;
      if (launch && busy)                         err_set = 1'b1;
    end
  end

  always_comb begin
    a_ptr_d     = a_ptr_q;
    b_ptr_d     = b_ptr_q;
    len_d       = len_q;
    res_ptr_d   = res_ptr_q;
    result_d    = result_q;
    done_d      = done_q;
    err_d       = err_q;
    start_d     = 1'b0;
    eng_state_d = eng_state_q;

    if (wr_ok && !busy) begin
      case (idx)
        CSR_A_PTR:   a_ptr_d   = io_cmd_data_i;
        CSR_B_PTR:   b_ptr_d   = io_cmd_data_i;
        CSR_LEN:     len_d     = io_cmd_data_i[31:0];
        CSR_RES_PTR: res_ptr_d = io_cmd_data_i;
        default: ;
      endcase
    end

    if (wr_ok && (idx == CSR_CLEAR)) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    if (err_set) err_d = 1'b1;

    // A zero-length launch completes immediately without bothering the engine.
    if (launch && !busy) begin
      if (len_q != 32'd0) begin
        start_d     = 1'b1;
        eng_state_d = E_BUSY;
        done_d      = 1'b0;
      end else begin
        done_d   = 1'b1;
        result_d = '0;
      end
    end

    // Completion is applied last so it overrides a coincident CLEAR.
    if (busy && done_i) begin
      result_d    = result_i;
      done_d      = 1'b1;
      eng_state_d = E_IDLE;
    end
  end

  always_comb begin
    cmd_state_d = cmd_state_q;
    resp_wr_d   = resp_wr_q;
    resp_addr_d = resp_addr_q;
    resp_size_d = resp_size_q;
    resp_data_d = resp_data_q;
    if (accept) begin
      cmd_state_d = S_RESP;
      resp_wr_d   = io_cmd_wr_i;
      resp_addr_d = io_cmd_addr_i;
      resp_size_d = io_cmd_size_i;
      resp_data_d = (!io_cmd_wr_i && in_win && aligned) ? rd_data : '0;
    end else if ((cmd_state_q == S_RESP) && io_resp_yumi_i) begin
      cmd_state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_state_q <= S_IDLE;
      eng_state_q <= E_IDLE;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      a_ptr_q     <= '0;
      b_ptr_q     <= '0;
      len_q       <= '0;
      res_ptr_q   <= '0;
      result_q    <= '0;
      resp_wr_q   <= 1'b0;
      resp_addr_q <= '0;
      resp_size_q <= '0;
      resp_data_q <= '0;
    end else begin
      cmd_state_q <= cmd_state_d;
      eng_state_q <= eng_state_d;
      start_q     <= start_d;
      done_q      <= done_d;
      err_q       <= err_d;
      a_ptr_q     <= a_ptr_d;
      b_ptr_q     <= b_ptr_d;
      len_q       <= len_d;
      res_ptr_q   <= res_ptr_d;
      result_q    <= result_d;
      resp_wr_q   <= resp_wr_d;
      resp_addr_q <= resp_addr_d;
      resp_size_q <= resp_size_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign io_cmd_ready_o = (cmd_state_q == S_IDLE);
  assign io_resp_v_o    = (cmd_state_q == S_RESP);
  assign io_resp_wr_o   = resp_wr_q;
  assign io_resp_addr_o = resp_addr_q;
  assign io_resp_size_o = resp_size_q;
  assign io_resp_data_o = resp_data_q;
  assign start_o        = start_q;
  assign a_ptr_o        = a_ptr_q[paddr_width_p-1:0];
  assign b_ptr_o        = b_ptr_q[paddr_width_p-1:0];
  assign res_ptr_o      = res_ptr_q[paddr_width_p-1:0];
  assign len_o          = len_q;

endmodule

// File: tb/tb_bp_cacc_csr_slave.sv
// Directed bench for bp_cacc_csr_slave: CSR access, engine launch/complete, error and reset cases.
module tb_bp_cacc_csr_slave;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        io_cmd_v_i = 1'b0;
  logic        io_cmd_ready_o;
  logic        io_cmd_wr_i = 1'b0;
  logic [39:0] io_cmd_addr_i = '0;
  logic [1:0]  io_cmd_size_i = '0;
  logic [63:0] io_cmd_data_i = '0;
  logic        io_resp_v_o;
  logic        io_resp_yumi_i = 1'b0;
  logic        io_resp_wr_o;
  logic [39:0] io_resp_addr_o;
  logic [1:0]  io_resp_size_o;
  logic [63:0] io_resp_data_o;
  logic        start_o;
  logic [39:0] a_ptr_o, b_ptr_o, res_ptr_o;
  logic [31:0] len_o;
  logic        done_i = 1'b0;
  logic [63:0] result_i = '0;

  int n_chk = 0;
  int n_pass = 0;
  int start_cnt = 0;
  int s0;

  bp_cacc_csr_slave dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o), .io_cmd_wr_i(io_cmd_wr_i),
    .io_cmd_addr_i(io_cmd_addr_i), .io_cmd_size_i(io_cmd_size_i), .io_cmd_data_i(io_cmd_data_i),
    .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i), .io_resp_wr_o(io_resp_wr_o),
    .io_resp_addr_o(io_resp_addr_o), .io_resp_size_o(io_resp_size_o), .io_resp_data_o(io_resp_data_o),
    .start_o(start_o), .a_ptr_o(a_ptr_o), .b_ptr_o(b_ptr_o), .res_ptr_o(res_ptr_o),
    .len_o(len_o), .done_i(done_i), .result_i(result_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (start_o) start_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One complete command/response transaction; optional done_i pulse in the accept cycle.
  task automatic do_cmd(input string tag, input logic wr, input logic [39:0] addr,
                        input logic [1:0] size, input logic [63:0] data, input logic [63:0] exp,
                        input int hold, input logic dn, input logic [63:0] res);
    int w;
    w = 0;
    @(negedge clk_i);
    while (!io_cmd_ready_o && w < 50) begin @(negedge clk_i); w++; end
    chk({tag, "_ready"}, 64'(io_cmd_ready_o), 64'd1);
    io_cmd_v_i = 1'b1; io_cmd_wr_i = wr; io_cmd_addr_i = addr;
    io_cmd_size_i = size; io_cmd_data_i = data;
    if (dn) begin done_i = 1'b1; result_i = res; end
    @(posedge clk_i); #1;
    io_cmd_v_i = 1'b0; done_i = 1'b0;
    w = 0;
    @(negedge clk_i);
    while (!io_resp_v_o && w < 50) begin @(negedge clk_i); w++; end
    chk({tag, "_resp_v"}, 64'(io_resp_v_o), 64'd1);
    if (hold > 0) begin
      repeat (hold) @(negedge clk_i);
      chk({tag, "_hold_ready"}, 64'(io_cmd_ready_o), 64'd0);
      chk({tag, "_hold_v"}, 64'(io_resp_v_o), 64'd1);
    end
    chk({tag, "_wr"}, 64'(io_resp_wr_o), 64'(wr));
    chk({tag, "_addr"}, 64'(io_resp_addr_o), 64'(addr));
    chk({tag, "_size"}, 64'(io_resp_size_o), 64'(size));
    chk({tag, "_data"}, io_resp_data_o, exp);
    io_resp_yumi_i = 1'b1;
    @(posedge clk_i); #1;
    io_resp_yumi_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_post_ready"}, 64'(io_cmd_ready_o), 64'd1);
    chk({tag, "_post_v"}, 64'(io_resp_v_o), 64'd0);
  endtask

  task automatic wr8(input string tag, input logic [39:0] addr, input logic [63:0] data);
    do_cmd(tag, 1'b1, addr, 2'd3, data, 64'd0, 0, 1'b0, 64'd0);
  endtask

  task automatic rd8(input string tag, input logic [39:0] addr, input logic [63:0] exp);
    do_cmd(tag, 1'b0, addr, 2'd3, 64'd0, exp, 0, 1'b0, 64'd0);
  endtask

  task automatic pulse_done(input logic [63:0] res);
    @(negedge clk_i);
    done_i = 1'b1; result_i = res;
    @(posedge clk_i); #1;
    done_i = 1'b0;
  endtask

  initial begin
    #23 reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", 64'(io_cmd_ready_o), 64'd1);
    chk("rst_resp_v", 64'(io_resp_v_o), 64'd0);
    chk("rst_start", 64'(start_o), 64'd0);
    chk("rst_len", 64'(len_o), 64'd0);
    chk("rst_resp_data", io_resp_data_o, 64'd0);
    rd8("rst_status", 40'h08, 64'd0);

    // Basic store/load of A_PTR
    wr8("wr_aptr", 40'h10, 64'h1000);
    rd8("rd_aptr", 40'h10, 64'h1000);
    chk("aptr_o", 64'(a_ptr_o), 64'h1000);
    wr8("wr_bptr", 40'h18, 64'h2000);
    wr8("wr_rptr", 40'h28, 64'h3000);
    chk("bptr_o", 64'(b_ptr_o), 64'h2000);
    chk("rptr_o", 64'(res_ptr_o), 64'h3000);

    // Launch and completion
    wr8("wr_len4", 40'h20, 64'd4);
    chk("len_o", 64'(len_o), 64'd4);
    s0 = start_cnt;
    wr8("wr_start", 40'h00, 64'd1);
    repeat (3) @(negedge clk_i);
    chk("start_pulses", 64'(start_cnt - s0), 64'd1);
    rd8("st_busy", 40'h08, 64'h1);
    rd8("rd_start", 40'h00, 64'd0);
    pulse_done(64'h2A);
    rd8("st_done", 40'h08, 64'h2);
    rd8("rd_result", 40'h30, 64'h2A);

    // Writes while busy are dropped
    s0 = start_cnt;
    wr8("wr_start2", 40'h00, 64'd1);
    rd8("st_busy2", 40'h08, 64'h1);
    wr8("wr_len_busy", 40'h20, 64'd9);
    wr8("wr_start_busy", 40'h00, 64'd1);
    repeat (2) @(negedge clk_i);
    chk("busy_start_pulses", 64'(start_cnt - s0), 64'd1);
    rd8("rd_len_busy", 40'h20, 64'd4);
    rd8("st_busy_err", 40'h08, 64'h5);
    pulse_done(64'h55);
    rd8("st_done_err", 40'h08, 64'h6);
    wr8("clear1", 40'h38, 64'd0);
    rd8("st_cleared", 40'h08, 64'h0);

    // done_i coincident with CLEAR: done wins
    wr8("wr_start3", 40'h00, 64'd1);
    do_cmd("clear_done", 1'b1, 40'h38, 2'd3, 64'd0, 64'd0, 0, 1'b1, 64'h77);
    rd8("st_done_wins", 40'h08, 64'h2);
    rd8("rd_result77", 40'h30, 64'h77);
    wr8("clear2", 40'h38, 64'd0);

    // Stray done_i while idle is ignored
    pulse_done(64'h99);
    rd8("rd_result_stray", 40'h30, 64'h77);
    rd8("st_stray", 40'h08, 64'h0);

    // Zero-length launch
    wr8("wr_len0", 40'h20, 64'd0);
    s0 = start_cnt;
    wr8("wr_start_len0", 40'h00, 64'd1);
    repeat (2) @(negedge clk_i);
    chk("len0_pulses", 64'(start_cnt - s0), 64'd0);
    rd8("st_len0", 40'h08, 64'h2);
    rd8("rd_result0", 40'h30, 64'h0);
    wr8("clear3", 40'h38, 64'd0);

    // Response back-pressure
    do_cmd("hold", 1'b0, 40'h10, 2'd3, 64'd0, 64'h1000, 10, 1'b0, 64'd0);

    // Error cases
    rd8("rd_oow", 40'h44, 64'd0);
    rd8("st_oow", 40'h08, 64'h4);
    wr8("clear4", 40'h38, 64'd0);
    wr8("wr_len5", 40'h20, 64'd5);
    do_cmd("wr_len_4b", 1'b1, 40'h20, 2'd2, 64'd7, 64'd0, 0, 1'b0, 64'd0);
    rd8("rd_len5", 40'h20, 64'd5);
    rd8("st_size_err", 40'h08, 64'h4);
    wr8("clear5", 40'h38, 64'd0);
    rd8("rd_unaligned", 40'h12, 64'd0);
    rd8("st_unal_err", 40'h08, 64'h4);
    wr8("clear6", 40'h38, 64'd0);
    wr8("wr_result", 40'h30, 64'h1234);
    rd8("rd_result_ro", 40'h30, 64'h0);
    rd8("st_ro_err", 40'h08, 64'h4);

    // Asynchronous reset while busy
    wr8("wr_start_rst", 40'h00, 64'd1);
    rd8("st_busy_rst", 40'h08, 64'h5);
    @(negedge clk_i);
    io_cmd_v_i = 1'b1; io_cmd_wr_i = 1'b0; io_cmd_addr_i = 40'h08; io_cmd_size_i = 2'd3;
    @(posedge clk_i); #1;
    io_cmd_v_i = 1'b0;
    #2 reset_n_i = 1'b0;
    #1;
    chk("arst_ready", 64'(io_cmd_ready_o), 64'd1);
    chk("arst_resp_v", 64'(io_resp_v_o), 64'd0);
    chk("arst_start", 64'(start_o), 64'd0);
    chk("arst_aptr", 64'(a_ptr_o), 64'd0);
    chk("arst_len", 64'(len_o), 64'd0);
    chk("arst_resp_addr", 64'(io_resp_addr_o), 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    rd8("st_after_rst", 40'h08, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
